// File: rtl/movsum_pkg.sv
// movsum_pkg: shared constants, width helper and term type for the
// moving_sum_accumulator slice.
package movsum_pkg;

  // Legal window depths and the widest sample the term helper supports.
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 256;
  localparam int N_MAX     = 32;

  // Widest possible signed term/sum over all legal configurations.
  localparam int SW_MAX = N_MAX + $clog2(DEPTH_MAX) + 1;

  // Signed term/sum type at its widest.
  // Each instance keeps only the low SW bits, which is exact in two's complement.
  typedef logic signed [SW_MAX-1:0] term_t;

  // Signed width that holds DEPTH*(2^n-1) in magnitude without overflow.
  function automatic int sw(input int n, input int depth);
    return n + $clog2(depth) + 1;
  endfunction

  // Zero-extend the unsigned sample, then negate it when the sample subtracts.
  function automatic term_t make_term(input logic [N_MAX-1:0] x, input logic sub);
    term_t t;
    t = term_t'({{(SW_MAX-N_MAX){1'b0}}, x});
    return sub ? -t : t;
  endfunction

endpackage

// File: rtl/moving_sum_accumulator_window_buffer.sv
// window_buffer: DEPTH-entry circular store of signed terms.
// The entry at the write pointer is always the oldest term.
// Each write replaces that entry and advances the pointer.
// Reset and clear zero every entry, so a refilling window sums correctly.
module window_buffer
  import movsum_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SW    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_we,
  input  logic signed [SW-1:0] i_wdata,
  output logic signed [SW-1:0] o_oldest
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] WP_LAST = PW'(DEPTH - 1);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
    $error("window_buffer: DEPTH out of range");
  end

  logic signed [SW-1:0] r_buf [DEPTH];
  logic [PW-1:0]        r_wp;

  // Overwrite the oldest entry on write; wrap the pointer explicitly so non-power-of-2 depths work.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wp <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (i_we) begin
      r_buf[r_wp] <= i_wdata;
      r_wp        <= (r_wp == WP_LAST) ? '0 : r_wp + 1'b1;
    end
  end

  // Read before the write, so the caller sees the term being evicted.
  assign o_oldest = r_buf[r_wp];

endmodule

// File: rtl/moving_sum_accumulator.sv
// moving_sum_accumulator: signed sum of the last DEPTH accepted samples.
// Each sample is added or subtracted according to its add_n bit.
// Optional feature macro: MOVSUM_AVG_EN adds the avg output (window mean, floor).
// Defining it also requires DEPTH to be a power of 2.
// Outputs are registered, so a load at an edge is reflected right after that edge.
module moving_sum_accumulator
  import movsum_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N-1:0]                  X,
  input  logic                          load,
  input  logic                          add_n,
  input  logic                          clear,
  output logic signed [sw(N,DEPTH)-1:0] Q,
  output logic                          q_valid
`ifdef MOVSUM_AVG_EN
  ,
  output logic signed [sw(N,DEPTH)-$clog2(DEPTH)-1:0] avg
`endif
);

  localparam int SW = sw(N, DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FC_FULL = FW'(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
    $error("moving_sum_accumulator: DEPTH must be in 2..256");
  end
  if (N < 1 || N > N_MAX) begin : g_n_chk
    $error("moving_sum_accumulator: N out of supported range");
  end
`ifdef MOVSUM_AVG_EN
  if ((1 << AW) != DEPTH) begin : g_pow2_chk
    $error("moving_sum_accumulator: MOVSUM_AVG_EN needs a power-of-2 DEPTH");
  end
`endif

  term_t                w_term_wide;
  logic signed [SW-1:0] w_term;
  logic signed [SW-1:0] w_oldest;
  logic signed [SW-1:0] w_sum_next;
  logic [FW-1:0]        w_fc_next;

  logic signed [SW-1:0] r_sum;
  logic [FW-1:0]        r_fc;
  logic                 r_q_valid;

  // Build the signed term for the incoming sample; its low SW bits are exact.
  assign w_term_wide = make_term(N_MAX'(X), add_n);
  assign w_term      = w_term_wide[SW-1:0];

  window_buffer #(
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_window_buffer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (clear),
    .i_we     (load),
    .i_wdata  (w_term),
    .o_oldest (w_oldest)
  );

  // Next running sum uses the pre-overwrite oldest term; fill count saturates at DEPTH.
  always_comb begin
    w_sum_next = r_sum + w_term - w_oldest;
    w_fc_next  = (r_fc == FC_FULL) ? r_fc : r_fc + 1'b1;
  end

  // Sum, fill counter and valid pulse; reset/clear flush, and a load under clear is dropped.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_sum     <= '0;
      r_fc      <= '0;
      r_q_valid <= 1'b0;
    end else if (load) begin
      r_sum     <= w_sum_next;
      r_fc      <= w_fc_next;
      r_q_valid <= (w_fc_next == FC_FULL);
    end else begin
      r_q_valid <= 1'b0;
    end
  end

  assign Q       = r_sum;
  assign q_valid = r_q_valid;

`ifdef MOVSUM_AVG_EN
  logic signed [SW-AW-1:0] r_avg;

  // Window mean: keeping the upper bits of the sum equals an arithmetic shift right (floor).
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_avg <= '0;
    end else if (load) begin
      r_avg <= w_sum_next[SW-1:AW];
    end
  end

  assign avg = r_avg;
`endif

endmodule

// File: tb/tb_moving_sum_accumulator.sv
// Directed, table-driven bench for moving_sum_accumulator.
// It uses a DEPTH=4 instance for the main vectors and a DEPTH=3 instance for wrap/extremes.
module tb_moving_sum_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       reset4, load4, add_n4, clear4;
  logic [3:0] x4;
  logic signed [6:0] q4;
  logic       v4;
`ifdef MOVSUM_AVG_EN
  logic signed [4:0] avg4;
`endif

  moving_sum_accumulator #(.N(4), .DEPTH(4)) dut4 (
    .clk     (clk),
    .reset   (reset4),
    .X       (x4),
    .load    (load4),
    .add_n   (add_n4),
    .clear   (clear4),
    .Q       (q4),
    .q_valid (v4)
`ifdef MOVSUM_AVG_EN
    ,
    .avg     (avg4)
`endif
  );

`ifndef MOVSUM_AVG_EN
  // DEPTH=3 instance (non-power-of-2, so only in the default build)
  logic       reset3, load3, add_n3, clear3;
  logic [3:0] x3;
  logic signed [6:0] q3;
  logic       v3;

  moving_sum_accumulator #(.N(4), .DEPTH(3)) dut3 (
    .clk     (clk),
    .reset   (reset3),
    .X       (x3),
    .load    (load3),
    .add_n   (add_n3),
    .clear   (clear3),
    .Q       (q3),
    .q_valid (v3)
  );
`endif

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- vector table (DEPTH=4) ----------------
  typedef struct {
    logic       rst;
    logic       clr;
    logic       ld;
    logic       sub;
    logic [3:0] x;
    int         exp_q;
    logic       exp_v;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic clr, input logic ld,
                              input logic sub, input int x, input int q, input logic v);
    vec_t r;
    r.rst = rst; r.clr = clr; r.ld = ld; r.sub = sub; r.x = 4'(x);
    r.exp_q = q; r.exp_v = v;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive4(input vec_t v);
    @(negedge clk);
    reset4 = v.rst; clear4 = v.clr; load4 = v.ld; add_n4 = v.sub; x4 = v.x;
    @(posedge clk);
    #1;
  endtask

`ifndef MOVSUM_AVG_EN
  task automatic drive3(input logic rst, input logic ld, input logic sub, input int x);
    @(negedge clk);
    reset3 = rst; clear3 = 1'b0; load3 = ld; add_n3 = sub; x3 = 4'(x);
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    reset4 = 1'b1; clear4 = 1'b0; load4 = 1'b0; add_n4 = 1'b0; x4 = '0;
`ifndef MOVSUM_AVG_EN
    reset3 = 1'b1; clear3 = 1'b0; load3 = 1'b0; add_n3 = 1'b0; x3 = '0;
`endif

    // rst clr ld sub x   Q   v
    vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0)); // reset state
    // fill 1,2,3,4 then slide with 5
    vecs.push_back(mk(0, 0, 1, 0, 1,   1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2,   3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3,   6, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4,  10, 1));
    vecs.push_back(mk(0, 0, 1, 0, 5,  14, 1));
    vecs.push_back(mk(0, 0, 0, 0, 9,  14, 0)); // idle: Q holds, no pulse
    // refill 1..4, then subtract 6 and four subtracts of 15
    vecs.push_back(mk(1, 0, 1, 0, 9,   0, 0)); // reset beats load
    vecs.push_back(mk(0, 0, 1, 0, 1,   1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2,   3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3,   6, 0));
    vecs.push_back(mk(0, 0, 1, 0, 4,  10, 1));
    vecs.push_back(mk(0, 0, 1, 1, 6,   3, 1));
    vecs.push_back(mk(0, 0, 1, 1, 15, -14, 1));
    vecs.push_back(mk(0, 0, 1, 1, 15, -32, 1));
    vecs.push_back(mk(0, 0, 1, 1, 15, -51, 1));
    vecs.push_back(mk(0, 0, 1, 1, 15, -60, 1));
    // clear with load after a full window: sample dropped, refill restarts
    vecs.push_back(mk(0, 1, 1, 0, 7,   0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1,   1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1,   2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1,   3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1,   4, 1));
    // reset mid-fill after two loads
    vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2,   2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 2,   4, 0));
    vecs.push_back(mk(1, 0, 1, 0, 9,   0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3,   3, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3,   6, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3,   9, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3,  12, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  12, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,   0, 0)); // clear alone

    for (int i = 0; i < vecs.size(); i++) begin
      drive4(vecs[i]);
      check($sformatf("d4_q[%0d]", i), int'(q4), vecs[i].exp_q);
      check($sformatf("d4_v[%0d]", i), int'(v4), int'(vecs[i].exp_v));
    end

`ifdef MOVSUM_AVG_EN
    // Average: window -1,-1,-1,0 -> Q=-3, avg=-1; then window 4,4,4,5 -> Q=17, avg=4
    drive4(mk(1, 0, 0, 0, 0, 0, 0));
    check("avg_reset", int'(avg4), 0);
    drive4(mk(0, 0, 1, 1, 1, 0, 0));
    drive4(mk(0, 0, 1, 1, 1, 0, 0));
    drive4(mk(0, 0, 1, 1, 1, 0, 0));
    drive4(mk(0, 0, 1, 0, 0, 0, 0));
    check("avg_neg_q", int'(q4), -3);
    check("avg_neg", int'(avg4), -1);
    drive4(mk(0, 0, 1, 0, 4, 0, 0));
    drive4(mk(0, 0, 1, 0, 4, 0, 0));
    drive4(mk(0, 0, 1, 0, 4, 0, 0));
    drive4(mk(0, 0, 1, 0, 5, 0, 0));
    check("avg_pos_q", int'(q4), 17);
    check("avg_pos", int'(avg4), 4);
`else
    // DEPTH=3: max positive and negative windows, pointer wraps every 3 loads
    begin
      int exp_pos[5] = '{15, 30, 45, 45, 45};
      int exp_neg[5] = '{15, -15, -45, -45, -45};
      int exp_vp[5]  = '{0, 0, 1, 1, 1};
      drive3(1'b1, 1'b0, 1'b0, 0);
      check("d3_reset_q", int'(q3), 0);
      check("d3_reset_v", int'(v3), 0);
      for (int i = 0; i < 5; i++) begin
        drive3(1'b0, 1'b1, 1'b0, 15);
        check($sformatf("d3_pos_q[%0d]", i), int'(q3), exp_pos[i]);
        check($sformatf("d3_pos_v[%0d]", i), int'(v3), exp_vp[i]);
      end
      for (int i = 0; i < 5; i++) begin
        drive3(1'b0, 1'b1, 1'b1, 15);
        check($sformatf("d3_neg_q[%0d]", i), int'(q3), exp_neg[i]);
        check($sformatf("d3_neg_v[%0d]", i), int'(v3), 1);
      end
    end
`endif

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
